// File: rtl/mdu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_pkg : op encodings, default latencies and FSM state type     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package mdu_pkg;

    localparam logic [2:0] MDU_NOP   = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int c_mult_cycles = 5;
    localparam int c_div_cycles  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_arith : combinational 64-bit multiply/divide result generator |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p_hi,
    output logic [31:0] p_lo,
    output logic        div_by_zero
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_sdiv;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_ub_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_uprod = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_sdiv    = (op == MDU_DIV);
    assign w_ua      = (w_sdiv && a[31]) ? (~a + 32'd1) : a;
    assign w_ub      = (w_sdiv && b[31]) ? (~b + 32'd1) : b;
    assign w_ub_safe = (b == 32'd0) ? 32'd1 : w_ub;
    assign w_uq      = w_ua / w_ub_safe;
    assign w_ur      = w_ua % w_ub_safe;

    assign div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);

    always_comb begin
        p_hi = 32'd0;
        p_lo = 32'd0;
        case (op)
            MDU_MULT: begin
                p_hi = w_sprod[63:32];
                p_lo = w_sprod[31:0];
            end
            MDU_MULTU: begin
                p_hi = w_uprod[63:32];
                p_lo = w_uprod[31:0];
            end
            MDU_DIV: begin
                p_lo = (a[31] ^ b[31]) ? (~w_uq + 32'd1) : w_uq;
                p_hi = a[31] ? (~w_ur + 32'd1) : w_ur;
            end
            MDU_DIVU: begin
                p_lo = w_uq;
                p_hi = w_ur;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu : fixed-latency multiply/divide unit owning HI/LO            |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles,
    parameter int DIV_CYCLES  = c_div_cycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES);

    mdu_state_t  r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_p_hi, w_p_hi_nxt;
    logic [31:0] r_p_lo, w_p_lo_nxt;
    logic        r_dbz, w_dbz_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_dbz;
    logic        w_long;

    mdu_arith u_arith (
        .op          (op),
        .a           (a),
        .b           (b),
        .p_hi        (w_res_hi),
        .p_lo        (w_res_lo),
        .div_by_zero (w_res_dbz)
    );

    assign w_long = is_long_op(op);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        w_dbz_nxt   = r_dbz;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (start && w_long) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = ((op == MDU_DIV) || (op == MDU_DIVU)) ? c_div_load : c_mult_load;
                    w_p_hi_nxt  = w_res_hi;
                    w_p_lo_nxt  = w_res_lo;
                    w_dbz_nxt   = w_res_dbz;
                end else if (start && (op == MDU_MTHI)) begin
                    w_hi_nxt = a;
                end else if (start && (op == MDU_MTLO)) begin
                    w_lo_nxt = a;
                end
            end
            ST_RUN: begin
                // Any start seen here is dropped; the hazard unit should never issue one.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    if (!r_dbz) begin
                        w_hi_nxt = r_p_hi;
                        w_lo_nxt = r_p_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_p_hi  <= 32'd0;
            r_p_lo  <= 32'd0;
            r_dbz   <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_dbz   <= w_dbz_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign stall = busy | (start & w_long);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire
